// File: rtl/vblank_regen.sv
// Regenerates a clean vblank from hsync/vsync once the frame length has been
// stable for several frames; falls back to the core's own vblank otherwise.
module vblank_regen #(
  parameter int VBL_TOP     = 34,
  parameter int VBL_BOT_OFS = 25,
  parameter int LOCK_TOL    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       vb_in,
  input  logic       orig_mode,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       vblank_out,
  output logic [8:0] line_cnt,
  output logic [8:0] frame_lines,
  output logic       locked
);

  localparam logic [8:0]        LC_MAX = 9'd511;
  localparam logic [8:0]        LC_PRE = 9'd510;
  localparam logic [8:0]        TOP_L  = 9'(VBL_TOP);
  localparam logic [8:0]        MIN_L  = 9'(VBL_TOP + VBL_BOT_OFS);
  localparam logic [8:0]        OFS_L  = 9'(VBL_BOT_OFS);
  localparam logic signed [9:0] TOL_S  = 10'(LOCK_TOL);

  logic       r_hs_d;
  logic       r_vb_d;
  logic       r_vbl_gen;
  logic [8:0] r_vbl_start;
  logic [1:0] r_stable_cnt;

  logic              w_strobe;
  logic              w_edge;
  logic              w_len_ok;
  logic              w_match;
  logic              w_lost;
  logic signed [9:0] w_diff;
  logic [1:0]        w_stable_next;

  assign w_strobe = hs_in & ~r_hs_d;
  assign w_edge   = w_strobe & vs_in & ~vsync_out;
  assign w_len_ok = (line_cnt > MIN_L) && (line_cnt != LC_MAX);
  // 10-bit signed difference keeps |L - frame_lines| free of 9-bit wrap
  assign w_diff   = $signed({1'b0, line_cnt}) - $signed({1'b0, frame_lines});
  assign w_match  = (w_diff <= TOL_S) && (w_diff >= -TOL_S);
  assign w_lost   = (line_cnt >= LC_PRE);

  assign hsync_out = r_hs_d;

  always_comb begin
    w_stable_next = r_stable_cnt;
    if (w_edge) begin
      if (w_len_ok && w_match)
        w_stable_next = (r_stable_cnt == 2'd3) ? 2'd3 : r_stable_cnt + 2'd1;
      else
        w_stable_next = 2'd0;
    end else if (w_lost) begin
      w_stable_next = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_d     <= 1'b0;
      r_vb_d     <= 1'b0;
      vblank_out <= 1'b0;
    end else begin
      r_hs_d     <= hs_in;
      r_vb_d     <= vb_in;
      vblank_out <= (orig_mode | ~locked) ? r_vb_d : r_vbl_gen;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_out    <= 1'b0;
      line_cnt     <= 9'd0;
      frame_lines  <= 9'd0;
      locked       <= 1'b0;
      r_stable_cnt <= 2'd0;
      r_vbl_gen    <= 1'b0;
      r_vbl_start  <= LC_MAX;
    end else if (w_strobe) begin
      vsync_out    <= vs_in;
      r_stable_cnt <= w_stable_next;
      locked       <= (w_stable_next == 2'd3);
      if (w_edge) begin
        line_cnt <= 9'd0;
        if (w_len_ok) begin
          frame_lines <= line_cnt;
          r_vbl_start <= line_cnt - OFS_L;
        end
      end else if (line_cnt != LC_MAX) begin
        line_cnt <= line_cnt + 9'd1;
      end
      // Top-of-frame clear takes priority over the bottom set
      if (line_cnt == TOP_L)
        r_vbl_gen <= 1'b0;
      else if (line_cnt == r_vbl_start)
        r_vbl_gen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vblank_regen.sv
// Scoreboard bench for vblank_regen: a behavioural line model pushes the
// expected post-strobe state, which is popped and compared at end of line.
module tb_vblank_regen;

  localparam int VBL_TOP     = 34;
  localparam int VBL_BOT_OFS = 25;
  localparam int LOCK_TOL    = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       hs_in = 1'b0;
  logic       vs_in = 1'b0;
  logic       vb_in = 1'b0;
  logic       orig_mode = 1'b0;
  logic       hsync_out;
  logic       vsync_out;
  logic       vblank_out;
  logic [8:0] line_cnt;
  logic [8:0] frame_lines;
  logic       locked;

  vblank_regen #(
    .VBL_TOP    (VBL_TOP),
    .VBL_BOT_OFS(VBL_BOT_OFS),
    .LOCK_TOL   (LOCK_TOL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .vb_in      (vb_in),
    .orig_mode  (orig_mode),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .vblank_out (vblank_out),
    .line_cnt   (line_cnt),
    .frame_lines(frame_lines),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lc;
    int fl;
    bit lk;
    bit vs;
    bit vbl;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int m_line, m_fl, m_start, m_stable;
  bit m_locked, m_gen, m_vs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_line = 0; m_fl = 0; m_start = 511; m_stable = 0;
    m_locked = 0; m_gen = 0; m_vs = 0;
  endtask

  // Behavioural reference for one line strobe
  task automatic model_strobe(input bit vs, input bit vb);
    int   pre;
    int   diff;
    bit   edge_s;
    exp_t e;
    pre    = m_line;
    edge_s = vs && !m_vs;
    m_vs   = vs;
    if (pre == VBL_TOP) m_gen = 0;
    else if (pre == m_start) m_gen = 1;
    if (edge_s) begin
      m_line = 0;
      if (pre > VBL_TOP + VBL_BOT_OFS && pre < 511) begin
        diff = pre - m_fl;
        if (diff < 0) diff = -diff;
        m_stable = (diff <= LOCK_TOL) ? ((m_stable < 3) ? m_stable + 1 : 3) : 0;
        m_fl     = pre;
        m_start  = pre - VBL_BOT_OFS;
      end else begin
        m_stable = 0;
      end
    end else begin
      if (m_line < 511) m_line++;
      if (m_line == 511) m_stable = 0;
    end
    m_locked = (m_stable == 3);
    e.lc  = m_line;
    e.fl  = m_fl;
    e.lk  = m_locked;
    e.vs  = vs;
    e.vbl = (orig_mode || !m_locked) ? vb : m_gen;
    sb_q.push_back(e);
  endtask

  // One line: hs high for 2 clocks, low for 4
  task automatic do_line(input bit vs, input bit vb);
    exp_t e;
    @(negedge clk);
    hs_in = 1'b1; vs_in = vs; vb_in = vb;
    model_strobe(vs, vb);
    @(negedge clk);
    chk("hsync_out", hsync_out, 1);
    @(negedge clk);
    hs_in = 1'b0;
    repeat (3) @(negedge clk);
    e = sb_q.pop_front();
    chk("line_cnt",    line_cnt,    e.lc);
    chk("frame_lines", frame_lines, e.fl);
    chk("locked",      locked,      e.lk);
    chk("vsync_out",   vsync_out,   e.vs);
    chk("vblank_out",  vblank_out,  e.vbl);
  endtask

  task automatic part_frame(input int first, input int last);
    for (int i = first; i <= last; i++) do_line(i < 3, 1'($urandom_range(0, 1)));
  endtask

  task automatic edge_line();
    do_line(1'b1, 1'($urandom_range(0, 1)));
  endtask

  task automatic idle_lines(input int n);
    for (int i = 0; i < n; i++) do_line(1'b0, 1'($urandom_range(0, 1)));
  endtask

  // Counter runs 1..len after the opening edge, so the closing edge measures len
  task automatic do_frame(input int len);
    part_frame(1, len);
    edge_line();
    $display("frame len=%0d frame_lines=%0d locked=%0d", len, frame_lines, locked);
  endtask

  // vblank_out must track vb_in with exactly two clocks of delay
  task automatic vb_follow(input bit om);
    bit v[8];
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) orig_mode = om;
      if (k >= 2) chk("vb_follow", vblank_out, v[k-2]);
      v[k]  = 1'($urandom_range(0, 1));
      vb_in = v[k];
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hsync"},  hsync_out,   0);
    chk({tag, "_vsync"},  vsync_out,   0);
    chk({tag, "_vblank"}, vblank_out,  0);
    chk({tag, "_line"},   line_cnt,    0);
    chk({tag, "_flines"}, frame_lines, 0);
    chk({tag, "_locked"}, locked,      0);
  endtask

  initial begin
    model_reset();
    vb_in = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // NTSC lock-up
    edge_line();
    for (int k = 1; k <= 4; k++) begin
      do_frame(262);
      if (k == 3) chk("ntsc_pre_lock", locked, 0);
    end
    chk("ntsc_locked", locked, 1);
    chk("ntsc_flines", frame_lines, 262);

    // Original vblank forced through while locked
    vb_follow(1'b1);
    do_frame(262);
    chk("orig_still_locked", locked, 1);
    orig_mode = 1'b0;

    // Jitter within tolerance, then one frame beyond it
    do_frame(264); chk("jit_264a", locked, 1);
    do_frame(262); chk("jit_262a", locked, 1);
    do_frame(264); chk("jit_264b", locked, 1);
    do_frame(262); chk("jit_262b", locked, 1);
    do_frame(264); chk("jit_264c", locked, 1);
    do_frame(267);
    chk("jit_267_unlock", locked, 0);
    chk("jit_267_flines", frame_lines, 267);
    vb_follow(1'b0);

    // PAL lock
    for (int k = 1; k <= 4; k++) begin
      do_frame(312);
      if (k == 3) chk("pal_pre_lock", locked, 0);
    end
    chk("pal_locked", locked, 1);
    chk("pal_flines", frame_lines, 312);

    // Switch back to NTSC: unlock at the first edge, relock later
    do_frame(262);
    chk("sw_unlock", locked, 0);
    chk("sw_flines", frame_lines, 262);
    do_frame(262);
    do_frame(262);
    chk("sw_pre_lock", locked, 0);
    do_frame(262);
    chk("sw_relock", locked, 1);

    // Asynchronous reset at line 100, asserted between clock edges
    part_frame(1, 100);
    @(negedge clk);
    hs_in = 1'b1;
    #2 reset_n = 1'b0;
    #1 chk_all_zero("async_rst");
    sb_q.delete();
    @(negedge clk);
    hs_in = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    edge_line();
    chk("post_rst_edge0", locked, 0);
    do_frame(262);
    chk("post_rst_seed_locked", locked, 0);
    chk("post_rst_seed_flines", frame_lines, 262);
    for (int k = 0; k < 3; k++) do_frame(262);
    chk("post_rst_relock", locked, 1);

    // Lost vsync: counter saturates
    idle_lines(520);
    chk("sat_line", line_cnt, 511);
    chk("sat_locked", locked, 0);
    chk("sat_flines", frame_lines, 262);
    edge_line();
    chk("sat_edge_flines", frame_lines, 262);

    // Too-short frame is rejected
    do_frame(40);
    chk("short_flines", frame_lines, 262);
    chk("short_locked", locked, 0);
    chk("short_line", line_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
